// File: rtl/mem_lsu.sv
// Load/store memory stage: sized, lane-aligned bus accesses with
// sign/zero extension, fault reporting and a request watchdog.
module mem_lsu #(
  parameter int XLEN    = 32,
  parameter int RADDR   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               regwrite,
  input  logic               load,
  input  logic               store,
  input  logic               jal,
  input  logic               jalr,
  input  logic               branch_cond,
  input  logic [1:0]         size,
  input  logic               ld_unsigned,
  input  logic [XLEN-1:0]    target,
  input  logic [XLEN-1:0]    result,
  input  logic [XLEN-1:0]    store_data,
  input  logic [RADDR-1:0]   regD,
  input  logic               jal_flush,
  output logic [RADDR-1:0]   regD_ex,
  output logic [XLEN-1:0]    regD_val_ex,
  output logic               regwrite_ex,
  output logic               branch_flush,
  output logic [XLEN-1:0]    b_target,
  output logic               stall,
  output logic               regwriteF,
  output logic               jalF,
  output logic [RADDR-1:0]   regDF,
  output logic [XLEN-1:0]    targetF,
  output logic [XLEN-1:0]    regdataF,
  output logic               req,
  output logic               rw,
  output logic [XLEN-1:0]    addr,
  output logic [XLEN/8-1:0]  wstrb,
  output logic [XLEN-1:0]    data_write,
  input  logic [XLEN-1:0]    data_read,
  input  logic               dack,
  input  logic               derr,
  output logic               fault,
  output logic [1:0]         fault_cause,
  output logic [XLEN-1:0]    fault_addr
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              regwrite_f_q, regwrite_f_d;
  logic              jal_f_q, jal_f_d;
  logic [RADDR-1:0]  regd_f_q, regd_f_d;
  logic [XLEN-1:0]   target_f_q, target_f_d;
  logic [XLEN-1:0]   regdata_f_q, regdata_f_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic [XLEN-1:0]   faddr_q, faddr_d;

  logic [OB-1:0]     off;
  logic              misal;
  int                nbytes;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   lmask;
  logic              sgn;
  logic [XLEN-1:0]   ld_data;

  always_comb begin
    off    = result[OB-1:0];
    nbytes = 1 << size;
    unique case (size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = result[0];
      2'd2:    misal = |result[1:0];
      default: misal = (XLEN == 32) || (|result[2:0]);
    endcase
    for (int i = 0; i < NB; i++) begin
      wstrb[i] = (i >= int'(off)) &&
                 (i < int'(off) + nbytes);
    end
    addr       = {result[XLEN-1:OB], {OB{1'b0}}};
    rw         = ~store;
    data_write = store_data << {off, 3'b000};
    ld_shift   = data_read >> {off, 3'b000};
    for (int i = 0; i < XLEN; i++) begin
      lmask[i] = i < nbytes * 8;
    end
    unique case (size)
      2'd0:    sgn = ld_shift[7];
      2'd1:    sgn = ld_shift[15];
      2'd2:    sgn = ld_shift[31];
      default: sgn = ld_shift[XLEN-1];
    endcase
    ld_data = (ld_shift & lmask) |
              ((sgn && !ld_unsigned) ? ~lmask : '0);
  end

  logic access, wb_nop, ld_hit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    regD_ex      = regD;
    regD_val_ex  = result;
    regwrite_ex  = regwrite;
    branch_flush = 1'b0;
    b_target     = target;
    stall        = 1'b0;
    req          = 1'b0;
    regwrite_f_d = regwrite;
    jal_f_d      = jal | jalr;
    regd_f_d     = regD;
    target_f_d   = target;
    regdata_f_d  = result;
    fault_d      = 1'b0;
    cause_d      = cause_q;
    faddr_d      = faddr_q;
    access       = 1'b0;
    wb_nop       = 1'b0;
    ld_hit       = 1'b0;

    if (state_q == IDLE) begin
      if (jal_flush) begin
        regD_ex     = '0;
        regD_val_ex = '0;
        regwrite_ex = 1'b0;
        wb_nop      = 1'b1;
      end else if (branch_cond) begin
        branch_flush = 1'b1;
      end else if ((load | store) && misal) begin
        wb_nop  = 1'b1;
        fault_d = 1'b1;
        cause_d = 2'd1;
        faddr_d = result;
      end else if (load | store) begin
        access = 1'b1;
      end
    end else begin
      access = 1'b1;
    end

    if (access) begin
      req    = 1'b1;
      stall  = 1'b1;
      wb_nop = 1'b1;
      if (dack) begin
        stall   = 1'b0;
        state_d = IDLE;
        if (derr) begin
          fault_d = 1'b1;
          cause_d = 2'd2;
          faddr_d = result;
        end else begin
          wb_nop = 1'b0;
          ld_hit = load;
        end
      end else if (state_q == IDLE) begin
        state_d = WAIT;
        cnt_d   = '0;
      end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
        // Abort: release upstream now, drop req next cycle.
        stall   = 1'b0;
        state_d = IDLE;
        cnt_d   = '0;
        fault_d = 1'b1;
        cause_d = 2'd3;
        faddr_d = result;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (ld_hit) begin
      regD_val_ex = ld_data;
      regdata_f_d = ld_data;
    end
    if (wb_nop) begin
      regwrite_f_d = 1'b0;
      jal_f_d      = 1'b0;
      regd_f_d     = '0;
      target_f_d   = '0;
      regdata_f_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      regwrite_f_q <= 1'b0;
      jal_f_q      <= 1'b0;
      regd_f_q     <= '0;
      target_f_q   <= '0;
      regdata_f_q  <= '0;
      fault_q      <= 1'b0;
      cause_q      <= 2'd0;
      faddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      regwrite_f_q <= regwrite_f_d;
      jal_f_q      <= jal_f_d;
      regd_f_q     <= regd_f_d;
      target_f_q   <= target_f_d;
      regdata_f_q  <= regdata_f_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      faddr_q      <= faddr_d;
    end
  end

  assign regwriteF   = regwrite_f_q;
  assign jalF        = jal_f_q;
  assign regDF       = regd_f_q;
  assign targetF     = target_f_q;
  assign regdataF    = regdata_f_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_addr  = faddr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table, corner sequences
// and randomized accesses against a byte-level reference model.
module tb_mem_lsu;

  logic        clk, rst;
  logic        regwrite, load, store, jal, jalr, branch_cond;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] target, result, store_data;
  logic [4:0]  regD;
  logic        jal_flush;
  logic [4:0]  regD_ex;
  logic [31:0] regD_val_ex;
  logic        regwrite_ex, branch_flush;
  logic [31:0] b_target;
  logic        stall, regwriteF, jalF;
  logic [4:0]  regDF;
  logic [31:0] targetF, regdataF;
  logic        req, rw;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] data_write, data_read;
  logic        dack, derr, fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  mem_lsu #(.XLEN(32), .RADDR(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .regwrite(regwrite), .load(load),
    .store(store), .jal(jal), .jalr(jalr),
    .branch_cond(branch_cond), .size(size),
    .ld_unsigned(ld_unsigned), .target(target), .result(result),
    .store_data(store_data), .regD(regD), .jal_flush(jal_flush),
    .regD_ex(regD_ex), .regD_val_ex(regD_val_ex),
    .regwrite_ex(regwrite_ex), .branch_flush(branch_flush),
    .b_target(b_target), .stall(stall), .regwriteF(regwriteF),
    .jalF(jalF), .regDF(regDF), .targetF(targetF),
    .regdataF(regdataF), .req(req), .rw(rw), .addr(addr),
    .wstrb(wstrb), .data_write(data_write), .data_read(data_read),
    .dack(dack), .derr(derr), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear();
    regwrite = 0; load = 0; store = 0; jal = 0; jalr = 0;
    branch_cond = 0; size = 0; ld_unsigned = 0; target = 0;
    result = 0; store_data = 0; regD = 0; jal_flush = 0;
    data_read = 0; dack = 0; derr = 0;
  endtask

  typedef struct {
    logic        ld, st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] res, sd, rd;
    logic        derr, mis;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_rdata;
    logic        e_regw;
    logic [1:0]  e_cause;
  } vec_t;

  function automatic vec_t mk(
    logic ld, logic st, logic [1:0] sz, logic uns,
    logic [31:0] res, logic [31:0] sd, logic [31:0] rd,
    logic de, logic mis, logic [3:0] es, logic [31:0] ewd,
    logic [31:0] erd, logic erw, logic [1:0] ec);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.res = res;
    v.sd = sd; v.rd = rd; v.derr = de; v.mis = mis;
    v.e_strb = es; v.e_wd = ewd; v.e_rdata = erd;
    v.e_regw = erw; v.e_cause = ec;
    return v;
  endfunction

  function automatic logic [31:0] bmask(logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tab[12];

  initial begin
    vec_t v;
    int nst;
    int nb, off;
    logic mis, ok, ld, st, uns, de;
    logic [1:0] sz;
    logic [31:0] res, sd, rd, e_wd, ld_val, bm;
    logic [3:0] e_strb;
    logic [63:0] acc;

    tab[0]  = mk(1,0,0,0,32'h1003,0,32'h80FFFFFF,0,0,
                 4'b1000,0,32'hFFFFFF80,1,0);
    tab[1]  = mk(1,0,0,1,32'h1003,0,32'h80FFFFFF,0,0,
                 4'b1000,0,32'h00000080,1,0);
    tab[2]  = mk(0,1,1,0,32'h2002,32'h1234ABCD,0,0,0,
                 4'b1100,32'hABCD0000,32'h2002,0,0);
    tab[3]  = mk(1,0,1,0,32'h4002,0,32'h80017FFF,0,0,
                 4'b1100,0,32'hFFFF8001,1,0);
    tab[4]  = mk(1,0,1,1,32'h4000,0,32'h8001F00F,0,0,
                 4'b0011,0,32'h0000F00F,1,0);
    tab[5]  = mk(1,0,2,0,32'h5000,0,32'hDEADBEEF,0,0,
                 4'b1111,0,32'hDEADBEEF,1,0);
    tab[6]  = mk(0,1,0,0,32'h6001,32'h000000A5,0,0,0,
                 4'b0010,32'h0000A500,32'h6001,0,0);
    tab[7]  = mk(1,0,2,0,32'h3001,0,32'h11111111,0,1,
                 0,0,0,0,1);
    tab[8]  = mk(1,0,2,0,32'h5004,0,32'h22222222,1,0,
                 4'b1111,0,0,0,2);
    tab[9]  = mk(1,0,1,0,32'h4001,0,32'h33333333,0,1,
                 0,0,0,0,1);
    tab[10] = mk(1,0,0,0,32'h7002,0,32'h12345678,0,0,
                 4'b0100,0,32'h00000034,1,0);
    tab[11] = mk(0,1,2,0,32'h8000,32'hCAFEF00D,0,0,0,
                 4'b1111,32'hCAFEF00D,32'h8000,0,0);

    clear();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_regwriteF", regwriteF, 0);
    chk("rst_regdataF", regdataF, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_faddr", fault_addr, 0);
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);

    for (int i = 0; i < 12; i++) begin
      v = tab[i];
      load = v.ld; store = v.st; size = v.sz;
      ld_unsigned = v.uns; result = v.res; store_data = v.sd;
      data_read = v.rd; dack = 1; derr = v.derr;
      regwrite = v.ld; regD = 5'd7;
      #1;
      chk("tab_stall", stall, 0);
      chk("tab_req", req, !v.mis);
      chk("tab_rw", rw, !v.st);
      if (!v.mis) begin
        chk("tab_wstrb", wstrb, v.e_strb);
        chk("tab_addr", addr, v.res & 32'hFFFFFFFC);
        if (v.st)
          chk("tab_wdata", data_write & bmask(v.e_strb), v.e_wd);
      end
      @(posedge clk);
      #1;
      chk("tab_regwriteF", regwriteF, v.e_regw);
      chk("tab_regdataF", regdataF, v.e_rdata);
      chk("tab_fault", fault, v.e_cause != 0);
      if (v.e_cause != 0) begin
        chk("tab_cause", fault_cause, v.e_cause);
        chk("tab_faddr", fault_addr, v.res);
      end
    end

    // passthrough, branch and jal_flush
    clear();
    regwrite = 1; regD = 9; result = 32'h77; jal = 1;
    target = 32'h40;
    #1;
    chk("pt_regD_ex", regD_ex, 9);
    chk("pt_val_ex", regD_val_ex, 32'h77);
    chk("pt_regwrite_ex", regwrite_ex, 1);
    @(posedge clk);
    #1;
    chk("pt_regwriteF", regwriteF, 1);
    chk("pt_regDF", regDF, 9);
    chk("pt_regdataF", regdataF, 32'h77);
    chk("pt_jalF", jalF, 1);
    chk("pt_targetF", targetF, 32'h40);
    clear();
    branch_cond = 1; target = 32'h1234; load = 1;
    result = 32'h100;
    #1;
    chk("br_flush", branch_flush, 1);
    chk("br_target", b_target, 32'h1234);
    chk("br_req", req, 0);
    @(posedge clk);
    #1;
    clear();
    jal_flush = 1; regwrite = 1; regD = 3; result = 32'h55;
    load = 1; size = 2;
    #1;
    chk("jf_regwrite_ex", regwrite_ex, 0);
    chk("jf_val_ex", regD_val_ex, 0);
    chk("jf_req", req, 0);
    @(posedge clk);
    #1;
    chk("jf_regwriteF", regwriteF, 0);

    // delayed ack, jal_flush ignored while waiting
    clear();
    load = 1; regwrite = 1; regD = 4; size = 2;
    result = 32'h7000;
    for (int c = 0; c < 3; c++) begin
      jal_flush = (c == 1);
      #1;
      chk("dly_stall", stall, 1);
      chk("dly_req", req, 1);
      @(posedge clk);
      #1;
      chk("dly_nop", regwriteF, 0);
    end
    jal_flush = 0; dack = 1; data_read = 32'h0BADF00D;
    #1;
    chk("dly_done_stall", stall, 0);
    @(posedge clk);
    #1;
    chk("dly_regwriteF", regwriteF, 1);
    chk("dly_regdataF", regdataF, 32'h0BADF00D);
    clear();
    #1;
    chk("dly_idle_req", req, 0);

    // watchdog: issue cycle plus TIMEOUT-1 waiting cycles stall
    clear();
    load = 1; regwrite = 1; size = 2; result = 32'h8000;
    nst = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall) break;
      nst++;
      @(posedge clk);
    end
    chk("to_stall_cycles", nst, 4);
    chk("to_abort_req", req, 1);
    @(posedge clk);
    #1;
    chk("to_fault", fault, 1);
    chk("to_cause", fault_cause, 3);
    chk("to_faddr", fault_addr, 32'h8000);
    chk("to_regwriteF", regwriteF, 0);
    dack = 1; data_read = 32'h1111; result = 32'h8004;
    #1;
    chk("to_next_req", req, 1);
    chk("to_next_stall", stall, 0);
    @(posedge clk);
    #1;
    chk("to_next_regwriteF", regwriteF, 1);
    chk("to_next_regdataF", regdataF, 32'h1111);
    chk("to_next_fault", fault, 0);

    // reset abandons a pending access
    clear();
    load = 1; regwrite = 1; size = 2; result = 32'h9000;
    #1;
    chk("rw_req_issue", req, 1);
    @(posedge clk);
    #1;
    load = 0; rst = 1;
    #1;
    chk("rw_req_wait", req, 1);
    @(posedge clk);
    #1;
    rst = 0;
    chk("rw_req_after", req, 0);
    chk("rw_stall_after", stall, 0);
    chk("rw_regwriteF", regwriteF, 0);

    // randomized single-cycle accesses vs byte-level model
    for (int i = 0; i < 300; i++) begin
      clear();
      ld = 1'($urandom_range(0, 1)); st = !ld;
      sz = 2'($urandom_range(0, 2)); uns = 1'($urandom_range(0, 1));
      res = $urandom; sd = $urandom; rd = $urandom;
      de = ($urandom_range(0, 7) == 0);
      nb = 1 << sz;
      off = int'(res % 4);
      mis = (res % nb) != 0;
      ok = !mis && !de;
      e_strb = 0; e_wd = 0;
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + nb) begin
          e_strb[b] = 1;
          e_wd[8*b +: 8] = sd[8*(b-off) +: 8];
        end
      end
      acc = 0;
      if (!mis) begin
        for (int k = 0; k < nb; k++)
          acc[8*k +: 8] = rd[8*(off+k) +: 8];
        if (!uns && acc[8*nb-1])
          acc = acc | (~64'h0 << (8*nb));
      end
      ld_val = acc[31:0];
      bm = bmask(e_strb);
      load = ld; store = st; size = sz; ld_unsigned = uns;
      result = res; store_data = sd; data_read = rd;
      dack = 1; derr = de; regwrite = ld; regD = 5'd2;
      #1;
      chk("rnd_stall", stall, 0);
      chk("rnd_req", req, !mis);
      if (!mis) begin
        chk("rnd_wstrb", wstrb, e_strb);
        chk("rnd_addr", addr, res & 32'hFFFFFFFC);
        if (st) chk("rnd_wdata", data_write & bm, e_wd);
      end
      @(posedge clk);
      #1;
      chk("rnd_regwriteF", regwriteF, ld && ok);
      chk("rnd_regdataF", regdataF,
          ok ? (ld ? ld_val : res) : 32'h0);
      chk("rnd_fault", fault, !ok);
      if (!ok) begin
        chk("rnd_cause", fault_cause, mis ? 2'd1 : 2'd2);
        chk("rnd_faddr", fault_addr, res);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
